// File: rtl/axi_lite_decerr_slave_if.sv
// AXI-Lite slave-side bus bundle for the decode-error responder.
// The slave modport faces the crossbar and the master modport drives it.
interface axi_lite_decerr_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid;
  logic                    s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );
endinterface

// File: rtl/axi_lite_decerr_slave.sv
// Default AXI-Lite responder: completes every write/read with DECERR and
// keeps saturating error counters plus the last offending address.
module axi_lite_decerr_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_lite_decerr_slave_if.slave     s,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           wr_err_cnt,
  output logic [CNT_W-1:0]           rd_err_cnt,
  output logic [ADDR_WIDTH-1:0]      last_err_addr,
  output logic                       last_err_wr
);

  // GOT_AW / GOT_W stand in for the separate aw_held / w_held capture flags
  typedef enum logic [1:0] {WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic      aw_hs, w_hs, ar_hs;
  logic      unused_wdata;

  assign unused_wdata = ^{s.s_wdata, s.s_wstrb};

  assign s.s_bresp = 2'b11;
  assign s.s_rresp = 2'b11;
  assign s.s_rdata = DATA_WIDTH'(ERR_RDATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next     = wr_state;
    rd_next     = rd_state;
    s.s_awready = 1'b0;
    s.s_wready  = 1'b0;
    s.s_bvalid  = 1'b0;
    s.s_arready = 1'b0;
    s.s_rvalid  = 1'b0;

    unique case (wr_state)
      WR_IDLE: begin
        s.s_awready = 1'b1;
        s.s_wready  = 1'b1;
      end
      WR_GOT_AW: s.s_wready  = 1'b1;
      WR_GOT_W:  s.s_awready = 1'b1;
      WR_RESP:   s.s_bvalid  = 1'b1;
      default:   ;
    endcase

    s.s_arready = (rd_state == RD_IDLE);
    s.s_rvalid  = (rd_state == RD_RESP);

    aw_hs = s.s_awvalid && s.s_awready;
    w_hs  = s.s_wvalid  && s.s_wready;
    ar_hs = s.s_arvalid && s.s_arready;

    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_RESP;
        else if (aw_hs)    wr_next = WR_GOT_AW;
        else if (w_hs)     wr_next = WR_GOT_W;
      end
      WR_GOT_AW: if (w_hs)       wr_next = WR_RESP;
      WR_GOT_W:  if (aw_hs)      wr_next = WR_RESP;
      WR_RESP:   if (s.s_bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase

    unique case (rd_state)
      RD_IDLE: if (ar_hs)       rd_next = RD_RESP;
      RD_RESP: if (s.s_rready)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Clear beats increment; counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else begin
      if (aw_hs && (wr_err_cnt != '1)) wr_err_cnt <= wr_err_cnt + 1'b1;
      if (ar_hs && (rd_err_cnt != '1)) rd_err_cnt <= rd_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_err_addr <= '0;
      last_err_wr   <= 1'b0;
    end else if (aw_hs) begin
      last_err_addr <= s.s_awaddr;
      last_err_wr   <= 1'b1;
    end else if (ar_hs) begin
      last_err_addr <= s.s_araddr;
      last_err_wr   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_decerr_slave.sv
// Bench for axi_lite_decerr_slave: directed scenarios plus a randomized run
// against a transaction-level model; a second instance uses CNT_W=2.
module tb_axi_lite_decerr_slave;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          CMAX = 65535;

  logic clk = 1'b0;
  logic rst;
  logic clr_cnt, clr2;
  logic [15:0]   wr_cnt, rd_cnt;
  logic [AW-1:0] last_addr;
  logic          last_wr;
  logic [1:0]    wr_cnt2, rd_cnt2;
  logic [AW-1:0] last_addr2;
  logic          last_wr2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_decerr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axi_lite_decerr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  axi_lite_decerr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_RDATA(32'hDEAD_BEEF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s(bus.slave), .clr_cnt(clr_cnt),
    .wr_err_cnt(wr_cnt), .rd_err_cnt(rd_cnt),
    .last_err_addr(last_addr), .last_err_wr(last_wr)
  );

  axi_lite_decerr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_RDATA(32'hDEAD_BEEF), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .s(bus2.slave), .clr_cnt(clr2),
    .wr_err_cnt(wr_cnt2), .rd_err_cnt(rd_cnt2),
    .last_err_addr(last_addr2), .last_err_wr(last_wr2)
  );

  // Transaction-level model of the main instance
  logic          m_aw, m_w, m_b, m_r;
  int            m_wcnt, m_rcnt;
  logic [AW-1:0] m_last_addr;
  logic          m_last_wr;
  logic          hs_aw, hs_w, hs_ar;

  task automatic cycle();
    hs_aw = !rst && bus.s_awvalid && !m_aw && !m_b;
    hs_w  = !rst && bus.s_wvalid  && !m_w  && !m_b;
    hs_ar = !rst && bus.s_arvalid && !m_r;
    if (rst) begin
      m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
      m_wcnt = 0; m_rcnt = 0; m_last_addr = '0; m_last_wr = 0;
    end else begin
      if (m_b) begin
        if (bus.s_bready) m_b = 0;
      end else if ((m_aw || hs_aw) && (m_w || hs_w)) begin
        m_b = 1; m_aw = 0; m_w = 0;
      end else begin
        m_aw = m_aw || hs_aw;
        m_w  = m_w  || hs_w;
      end
      if (m_r) begin
        if (bus.s_rready) m_r = 0;
      end else if (hs_ar) m_r = 1;
      if (clr_cnt) begin
        m_wcnt = 0; m_rcnt = 0;
      end else begin
        if (hs_aw && m_wcnt < CMAX) m_wcnt++;
        if (hs_ar && m_rcnt < CMAX) m_rcnt++;
      end
      if (hs_aw) begin m_last_addr = bus.s_awaddr; m_last_wr = 1; end
      else if (hs_ar) begin m_last_addr = bus.s_araddr; m_last_wr = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
    bus.s_bready = 0; bus.s_rready = 0; clr_cnt = 0;
    bus.s_awaddr = '0; bus.s_araddr = '0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus2.s_awvalid = 0; bus2.s_wvalid = 0; bus2.s_arvalid = 0;
    bus2.s_bready = 0; bus2.s_rready = 0; clr2 = 0;
    bus2.s_awaddr = '0; bus2.s_araddr = '0; bus2.s_wdata = '0; bus2.s_wstrb = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cycle(); cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.s_awready !== 1'b1) begin miscompares++; $display("FAIL reset_awready got %0b want 1", bus.s_awready); end
    vectors++; if (bus.s_wready !== 1'b1) begin miscompares++; $display("FAIL reset_wready got %0b want 1", bus.s_wready); end
    vectors++; if (bus.s_arready !== 1'b1) begin miscompares++; $display("FAIL reset_arready got %0b want 1", bus.s_arready); end
    vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_valids got b=%0b r=%0b want 0", bus.s_bvalid, bus.s_rvalid); end
    vectors++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %0d/%0d want 0/0", wr_cnt, rd_cnt); end
    vectors++; if (last_addr !== 32'd0 || last_wr !== 1'b0) begin miscompares++; $display("FAIL reset_last got %0h/%0b want 0/0", last_addr, last_wr); end
    vectors++; if (bus.s_bresp !== 2'b11 || bus.s_rresp !== 2'b11) begin miscompares++; $display("FAIL resp_const got %0b/%0b want 11/11", bus.s_bresp, bus.s_rresp); end
    vectors++; if (bus.s_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rdata_const got %0h want deadbeef", bus.s_rdata); end
  endtask

  task automatic test_aw_w_same();
    do_reset();
    bus.s_awaddr = 32'h0000_5000; bus.s_awvalid = 1; bus.s_wvalid = 1;
    bus.s_wdata = $urandom; bus.s_bready = 1;
    cycle();
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    vectors++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b11) begin miscompares++; $display("FAIL same_bvalid got %0b/%0b want 1/11", bus.s_bvalid, bus.s_bresp); end
    vectors++; if (bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0) begin miscompares++; $display("FAIL same_readies_busy got %0b/%0b want 0/0", bus.s_awready, bus.s_wready); end
    vectors++; if (wr_cnt !== 16'd1) begin miscompares++; $display("FAIL same_wrcnt got %0d want 1", wr_cnt); end
    vectors++; if (last_addr !== 32'h5000 || last_wr !== 1'b1) begin miscompares++; $display("FAIL same_last got %0h/%0b want 5000/1", last_addr, last_wr); end
    cycle();
    vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1) begin miscompares++; $display("FAIL same_done got b=%0b aw=%0b w=%0b want 0 1 1", bus.s_bvalid, bus.s_awready, bus.s_wready); end
  endtask

  task automatic test_w_then_aw();
    do_reset();
    bus.s_wvalid = 1;
    cycle();
    bus.s_wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (bus.s_wready !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_bvalid !== 1'b0) begin miscompares++; $display("FAIL w_held got w=%0b aw=%0b b=%0b want 0 1 0", bus.s_wready, bus.s_awready, bus.s_bvalid); end
      cycle();
    end
    bus.s_awaddr = 32'h0000_1234; bus.s_awvalid = 1;
    cycle();
    bus.s_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.s_bvalid !== 1'b1 || bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0) begin miscompares++; $display("FAIL b_hold got b=%0b aw=%0b w=%0b want 1 0 0", bus.s_bvalid, bus.s_awready, bus.s_wready); end
      cycle();
    end
    bus.s_bready = 1;
    cycle();
    bus.s_bready = 0;
    vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1) begin miscompares++; $display("FAIL b_release got b=%0b aw=%0b w=%0b want 0 1 1", bus.s_bvalid, bus.s_awready, bus.s_wready); end
  endtask

  task automatic test_read_hold();
    do_reset();
    bus.s_araddr = 32'hFFFF_FFF0; bus.s_arvalid = 1;
    cycle();
    bus.s_arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.s_rvalid !== 1'b1 || bus.s_arready !== 1'b0 || bus.s_rdata !== 32'hDEAD_BEEF || bus.s_rresp !== 2'b11) begin miscompares++; $display("FAIL r_hold got rv=%0b ar=%0b d=%0h resp=%0b want 1 0 deadbeef 11", bus.s_rvalid, bus.s_arready, bus.s_rdata, bus.s_rresp); end
      cycle();
      if (i == 1) bus.s_rready = 1;
    end
    bus.s_rready = 0;
    vectors++; if (bus.s_rvalid !== 1'b0 || bus.s_arready !== 1'b1) begin miscompares++; $display("FAIL r_release got rv=%0b ar=%0b want 0 1", bus.s_rvalid, bus.s_arready); end
    vectors++; if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin miscompares++; $display("FAIL r_cnt got rd=%0d wr=%0d want 1 0", rd_cnt, wr_cnt); end
    vectors++; if (last_addr !== 32'hFFFF_FFF0 || last_wr !== 1'b0) begin miscompares++; $display("FAIL r_last got %0h/%0b want fffffff0/0", last_addr, last_wr); end
  endtask

  task automatic test_aw_ar_same();
    do_reset();
    bus.s_awaddr = 32'h4000; bus.s_awvalid = 1; bus.s_wvalid = 1;
    bus.s_araddr = 32'h8000; bus.s_arvalid = 1;
    bus.s_bready = 1; bus.s_rready = 1;
    cycle();
    bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
    vectors++; if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin miscompares++; $display("FAIL both_cnt got %0d/%0d want 1/1", wr_cnt, rd_cnt); end
    vectors++; if (last_addr !== 32'h4000 || last_wr !== 1'b1) begin miscompares++; $display("FAIL both_last got %0h/%0b want 4000/1", last_addr, last_wr); end
    vectors++; if (bus.s_bvalid !== 1'b1 || bus.s_rvalid !== 1'b1) begin miscompares++; $display("FAIL both_valid got %0b/%0b want 1/1", bus.s_bvalid, bus.s_rvalid); end
    cycle();
    vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0) begin miscompares++; $display("FAIL both_done got %0b/%0b want 0/0", bus.s_bvalid, bus.s_rvalid); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus2.s_rready = 1;
    for (int k = 1; k <= 5; k++) begin
      bus2.s_araddr = $urandom; bus2.s_arvalid = 1;
      cycle();
      bus2.s_arvalid = 0;
      vectors++; if (rd_cnt2 !== 2'((k > 3) ? 3 : k) || bus2.s_rvalid !== 1'b1) begin miscompares++; $display("FAIL sat_cnt got %0d rv=%0b want %0d 1", rd_cnt2, bus2.s_rvalid, (k > 3) ? 3 : k); end
      cycle();
    end
    bus2.s_arvalid = 1; clr2 = 1;
    cycle();
    bus2.s_arvalid = 0; clr2 = 0;
    vectors++; if (rd_cnt2 !== 2'd0 || bus2.s_rvalid !== 1'b1) begin miscompares++; $display("FAIL sat_clr got %0d rv=%0b want 0 1", rd_cnt2, bus2.s_rvalid); end
    cycle();
    bus2.s_rready = 0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_arvalid = 1; bus.s_araddr = 32'h77;
    cycle();
    bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
    rst = 1;
    cycle();
    rst = 0;
    vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1) begin miscompares++; $display("FAIL rst_drop got b=%0b r=%0b aw=%0b w=%0b want 0 0 1 1", bus.s_bvalid, bus.s_rvalid, bus.s_awready, bus.s_wready); end
    vectors++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || last_addr !== 32'd0) begin miscompares++; $display("FAIL rst_cnt got %0d/%0d last=%0h want 0/0 0", wr_cnt, rd_cnt, last_addr); end
    bus.s_wvalid = 1;
    cycle();
    bus.s_wvalid = 0;
    rst = 1;
    cycle();
    rst = 0;
    bus.s_awvalid = 1;
    cycle();
    bus.s_awvalid = 0;
    vectors++; if (bus.s_bvalid !== 1'b0 || bus.s_wready !== 1'b1) begin miscompares++; $display("FAIL rst_wheld got b=%0b w=%0b want 0 1", bus.s_bvalid, bus.s_wready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      vectors++;
      if (bus.s_awready !== (!m_aw && !m_b) || bus.s_wready !== (!m_w && !m_b) ||
          bus.s_bvalid !== m_b || bus.s_arready !== !m_r || bus.s_rvalid !== m_r) begin
        miscompares++;
        $display("FAIL rnd_hs cyc %0d got aw=%0b w=%0b b=%0b ar=%0b r=%0b want aw=%0b w=%0b b=%0b ar=%0b r=%0b",
                 n, bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_arready, bus.s_rvalid,
                 !m_aw && !m_b, !m_w && !m_b, m_b, !m_r, m_r);
      end
      vectors++;
      if (wr_cnt !== 16'(m_wcnt) || rd_cnt !== 16'(m_rcnt) || last_addr !== m_last_addr || last_wr !== m_last_wr) begin
        miscompares++;
        $display("FAIL rnd_log cyc %0d got %0d/%0d %0h/%0b want %0d/%0d %0h/%0b",
                 n, wr_cnt, rd_cnt, last_addr, last_wr, m_wcnt, m_rcnt, m_last_addr, m_last_wr);
      end
      if (!bus.s_awvalid || hs_aw) begin bus.s_awvalid = $urandom_range(0, 1); bus.s_awaddr = $urandom; end
      if (!bus.s_wvalid || hs_w) begin bus.s_wvalid = $urandom_range(0, 1); bus.s_wdata = $urandom; bus.s_wstrb = 4'($urandom); end
      if (!bus.s_arvalid || hs_ar) begin bus.s_arvalid = $urandom_range(0, 1); bus.s_araddr = $urandom; end
      bus.s_bready = $urandom_range(0, 1);
      bus.s_rready = $urandom_range(0, 1);
      clr_cnt = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_aw = 0; m_w = 0; m_b = 0; m_r = 0; m_wcnt = 0; m_rcnt = 0;
    m_last_addr = '0; m_last_wr = 0; hs_aw = 0; hs_w = 0; hs_ar = 0;
    test_reset();
    test_aw_w_same();
    test_w_then_aw();
    test_read_hold();
    test_aw_ar_same();
    test_saturate();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
